rw_bus_responder: RTL

- Responder end of the cache-side read/write request bus (req/reqtag/reqcyc/reqack, resp/resptag/respcyc/respack) whose initiator is the data-cache read/writeback arbiter.
- Accepts one line-sized transaction at a time, reads or writes an 8-word line in a backing synchronous memory, and returns either 8 read-data beats or one write-completion beat.
- Serves as the memory-side endpoint for arbiter and cache integration.

---
 rtl/rw_bus_responder_if.sv | 39 +++
 rtl/rw_bus_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rw_bus_responder_if.sv
// ---------------------------------------------------------------------------
// rw_bus_responder_if
//
// Cache-side read/write request bus between the data-cache arbiter
// (initiator, modport master) and a memory-side responder (modport slave).
//
// Signals:
//   req      initiator -> responder  byte address (address beat) or write data
//   reqtag   initiator -> responder  tag, MSB=1 read, MSB=0 write
//   reqcyc   initiator -> responder  request beat valid
//   reqack   responder -> initiator  one-cycle pulse, request beat accepted
//   resp     responder -> initiator  response data (all ones when idle)
//   resptag  responder -> initiator  echo of the accepted tag
//   respcyc  responder -> initiator  response beat valid
//   respack  initiator -> responder  current response beat accepted
// ---------------------------------------------------------------------------
interface rw_bus_responder_if #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 13
);
  logic [WIDTH-1:0]     req;
  logic [TAG_WIDTH-1:0] reqtag;
  logic                 reqcyc;
  logic                 reqack;
  logic [WIDTH-1:0]     resp;
  logic [TAG_WIDTH-1:0] resptag;
  logic                 respcyc;
  logic                 respack;

  modport master (
    output req, reqtag, reqcyc, respack,
    input  reqack, resp, resptag, respcyc
  );

  modport slave (
    input  req, reqtag, reqcyc, respack,
    output reqack, resp, resptag, respcyc
  );
endinterface

// File: rtl/rw_bus_responder.sv
// ---------------------------------------------------------------------------
// rw_bus_responder
//
// Memory-side endpoint of the cache read/write request bus. Accepts one
// 8-word line transaction at a time. Reads fetch the line from a synchronous
// memory (1-cycle read latency) into a line buffer and then return 8 beats;
// writes take 8 data beats straight into memory and return one completion
// beat with resp=0.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   bus        request/response bus (slave modport)
//   mem_addr   memory word address
//   mem_re     memory read strobe (data returns on mem_rdata one cycle later)
//   mem_we     memory write strobe
//   mem_wdata  memory write data
//   mem_rdata  memory read data
// ---------------------------------------------------------------------------
module rw_bus_responder #(
  parameter int WIDTH          = 64,
  parameter int TAG_WIDTH      = 13,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  rw_bus_responder_if.slave         bus,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [WIDTH-1:0]          mem_wdata,
  input  logic [WIDTH-1:0]          mem_rdata
);

  // Line number = word address without its 3 word-in-line bits.
  localparam int LINE_W = MEM_ADDR_WIDTH - 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_FETCH = 3'd1,
    RD_SEND  = 3'd2,
    WR_DATA  = 3'd3,
    WR_RESP  = 3'd4
  } state_t;

  state_t               state_q,     state_d;
  logic [2:0]           cnt_q,       cnt_d;       // beat counter k
  logic                 issued_q,    issued_d;    // all 8 reads issued
  logic                 cap_vld_q,   cap_vld_d;   // mem_rdata valid this cycle
  logic [2:0]           cap_idx_q,   cap_idx_d;   // line slot for mem_rdata
  logic [LINE_W-1:0]    base_q,      base_d;
  logic [TAG_WIDTH-1:0] tag_q,       tag_d;
  logic                 reqack_q,    reqack_d;
  logic                 mem_re_q,    mem_re_d;
  logic                 mem_we_q,    mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]     mem_wdata_q, mem_wdata_d;

  logic [WIDTH-1:0]     line_buf [0:7];
  logic [WIDTH-1:0]     resp_c;

  // Byte-offset bits and address bits above the memory are intentionally
  // dropped (line aligned, upper bits alias).
  logic unused_req_bits;
  assign unused_req_bits = ^{bus.req[WIDTH-1:MEM_ADDR_WIDTH+3], bus.req[5:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    issued_d    = issued_q;
    base_d      = base_q;
    tag_d       = tag_q;
    reqack_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Read data follows mem_re by exactly one cycle; remember which slot.
    cap_vld_d   = mem_re_q;
    cap_idx_d   = mem_addr_q[2:0];

    case (state_q)
      IDLE: begin
        // While reqack is high the current reqcyc belongs to the beat just
        // accepted, so it must not be taken again.
        if (bus.reqcyc && !reqack_q) begin
          reqack_d = 1'b1;
          base_d   = bus.req[MEM_ADDR_WIDTH+2:6];
          tag_d    = bus.reqtag;
          cnt_d    = 3'd0;
          issued_d = 1'b0;
          state_d  = bus.reqtag[TAG_WIDTH-1] ? RD_FETCH : WR_DATA;
        end
      end

      RD_FETCH: begin
        if (!issued_q) begin
          mem_re_d   = 1'b1;
          mem_addr_d = {base_q, cnt_q};
          cnt_d      = cnt_q + 3'd1;     // wraps to 0, ready for RD_SEND
          if (cnt_q == 3'd7) begin
            issued_d = 1'b1;
          end
        end
        if (cap_vld_q && (cap_idx_q == 3'd7)) begin
          state_d = RD_SEND;
        end
      end

      RD_SEND: begin
        if (bus.respack) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = IDLE;
          end
        end
      end

      WR_DATA: begin
        if (bus.reqcyc && !reqack_q) begin
          reqack_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {base_q, cnt_q};
          mem_wdata_d = bus.req;
          cnt_d       = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        if (bus.respack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      issued_q    <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= 3'd0;
      base_q      <= '0;
      tag_q       <= '0;
      reqack_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      issued_q    <= issued_d;
      cap_vld_q   <= cap_vld_d;
      cap_idx_q   <= cap_idx_d;
      base_q      <= base_d;
      tag_q       <= tag_d;
      reqack_q    <= reqack_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Line buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (cap_vld_q) begin
      line_buf[cap_idx_q] <= mem_rdata;
    end
  end

  always_comb begin
    resp_c = '1;
    if (state_q == RD_SEND) begin
      resp_c = line_buf[cnt_q];
    end else if (state_q == WR_RESP) begin
      resp_c = '0;
    end
  end

  assign bus.reqack  = reqack_q;
  assign bus.respcyc = (state_q == RD_SEND) || (state_q == WR_RESP);
  assign bus.resp    = resp_c;
  assign bus.resptag = tag_q;
  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
